// File: rtl/muldiv.sv
// muldiv: iterative MIPS HI/LO multiply/divide unit (shift-add multiply, restoring divide).
module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0] m, a_q, ma, mb, q, r;
  logic [WIDTH:0] mul_sum, div_r, div_d;
  logic is_div, neg_res, neg_rem, dz, accept, sa, sb;
  always_comb begin
    accept = state == IDLE && start && !cancel;
    busy = state != IDLE;
    sa = !op[0] && a[WIDTH-1];
    sb = !op[0] && b[WIDTH-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    div_r = acc[2*WIDTH-1:WIDTH-1];
    div_d = div_r - {1'b0, m};
    prod = neg_res ? -acc : acc;
    q = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept && !op[2]) state_n = CALC;
      CALC: if (cancel) state_n = IDLE; else if (cnt == CW'(1)) state_n = FIX;
      default: state_n = IDLE;
    endcase
  end
  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_ff @(posedge clk) begin
    if (rest) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      m <= '0;
      a_q <= '0;
      is_div <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      done <= state == FIX && !cancel;
      if (accept && op == 3'd4) hi <= a;
      if (accept && op == 3'd5) lo <= a;
      if (accept && !op[2]) begin
        is_div <= op[1];
        neg_res <= sa ^ sb;
        neg_rem <= sa;
        dz <= b == '0;
        a_q <= a;
        m <= op[1] ? mb : ma;
        acc <= {{WIDTH{1'b0}}, op[1] ? ma : mb};
        cnt <= CW'(WIDTH);
      end
      if (state == CALC) begin
        cnt <= cnt - CW'(1);
        acc <= !is_div ? {mul_sum, acc[WIDTH-1:1]} :
               div_d[WIDTH] ? {div_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
               {div_d[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
      if (state == FIX && !cancel) begin
        hi <= !is_div ? prod[2*WIDTH-1:WIDTH] : dz ? a_q : r;
        lo <= !is_div ? prod[WIDTH-1:0] : dz ? '1 : q;
      end
    end
  end
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: vector table plus hand sequences for cancel, MTHI/MTLO and reset.
module tb_muldiv;
  logic clk = 1'b0, rest = 1'b1, start = 1'b0, cancel = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  always #5 clk = ~clk;
  muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rest(rest), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  typedef struct {string nm; logic [2:0] op; logic [31:0] a, b, hi, lo;} vec_t;
  typedef struct {string nm; logic [31:0] hi, lo;} exp_t;
  vec_t vecs [14];
  exp_t sb_q [$];
  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input vec_t v);
    int lat;
    exp_t e;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    sb_q.push_back('{v.nm, v.hi, v.lo});
    step();
    start = 1'b0;
    chk({v.nm, " busy_after_accept"}, busy, 1);
    chk({v.nm, " done_pulse_width"}, done, 0);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk({v.nm, " latency"}, lat, 33);
    chk({v.nm, " busy_at_done"}, busy, 0);
    e = sb_q.pop_front();
    chk({e.nm, " hi"}, hi, e.hi);
    chk({e.nm, " lo"}, lo, e.lo);
  endtask
  initial begin
    int seen;
    vecs = '{
      '{"mult_m1x2",     3'd0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE},
      '{"multu_m1x2",    3'd1, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE},
      '{"mult_7xm3",     3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB},
      '{"mult_minxmin",  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
      '{"multu_max",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{"div_m7_2",      3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD},
      '{"div_7_m2",      3'd2, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
      '{"div_m7_m2",     3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003},
      '{"div_ovf",       3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{"div_by0",       3'd2, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF},
      '{"div_neg_by0",   3'd2, 32'hFFFFFFF0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF},
      '{"divu_max_16",   3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF},
      '{"divu_by0",      3'd3, 32'h80000001, 32'h0,        32'h80000001, 32'hFFFFFFFF},
      '{"divu_7_2",      3'd3, 32'h7,        32'h2,        32'h00000001, 32'h00000003}
    };
    step();
    step();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    rest = 1'b0;
    foreach (vecs[i]) run_op(vecs[i]);
    op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 3) begin op = 3'd4; a = 32'hDEADBEEF; start = 1'b1; end
      if (k == 4) start = 1'b0;
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel busy", busy, 0);
    chk("cancel done", done, 0);
    chk("cancel hi", hi, 32'h1);
    chk("cancel lo", lo, 32'h3);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) seen++;
    end
    chk("cancel no_done", seen, 0);
    chk("busy_start hi", hi, 32'h1);
    op = 3'd4; a = 32'hCAFEF00D; start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("idle_cancel blocks mthi", hi, 32'h1);
    op = 3'd4; a = 32'hCAFEF00D; start = 1'b1;
    step();
    start = 1'b0;
    chk("mthi hi", hi, 32'hCAFEF00D);
    chk("mthi lo", lo, 32'h3);
    chk("mthi busy", busy, 0);
    step();
    chk("mthi busy_later", busy, 0);
    chk("mthi done", done, 0);
    op = 3'd5; a = 32'h0BADF00D; start = 1'b1;
    step();
    start = 1'b0;
    chk("mtlo lo", lo, 32'h0BADF00D);
    chk("mtlo hi", hi, 32'hCAFEF00D);
    op = 3'd6; a = 32'h11111111; start = 1'b1;
    step();
    start = 1'b0;
    chk("nop busy", busy, 0);
    chk("nop hi", hi, 32'hCAFEF00D);
    chk("nop lo", lo, 32'h0BADF00D);
    op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rest = 1'b1;
    step();
    rest = 1'b0;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset hi", hi, 0);
    chk("midreset lo", lo, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) seen++;
    end
    chk("midreset no_done", seen, 0);
    run_op(vecs[13]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit providing the MIPS HI/LO register pair for the single-cycle core (MULT, MULTU, DIV, DIVU, MTHI, MTLO; MFHI/MFLO read `hi`/`lo` directly). It is parametrised in operand width. It computes over WIDTH+1 cycles while `busy` tells the control unit to stall the PC. It also accepts a `cancel` so COP0 exception entry can abort an in-flight operation.

## Interface
- `WIDTH`, default 32: operand width; `hi`/`lo` are each WIDTH bits.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rest`  in  1: synchronous, active-high reset.
- `start`  in  1: request; accepted only in IDLE with `cancel` low.
- `op`  in  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops.
- `cancel`  in  1: abort in-flight multiply/divide.
- `a`  in  WIDTH: rs operand (multiplicand / dividend / MTHI/MTLO data).
- `b`  in  WIDTH: rt operand (multiplier / divisor).
- `busy`  out  1: operation in flight; the core must stall any MFHI/MFLO/muldiv instruction.
- `done`  out  1: one-cycle pulse when `hi`/`lo` take a new mul/div result.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- States: IDLE, CALC, FIX.
- **Reset** (`rest`=1 at an edge, any state):
  - Go to IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - All internal accumulators and counters cleared.
  - `rest` has priority over everything.
- **IDLE, MTHI/MTLO** (`start`=1, op 4/5):
  - `hi` (or `lo`) ← `a` at that edge.
  - Stays IDLE; no `busy`, no `done`.
- **IDLE, mul/div** (`start`=1, op 0–3):
  - Latch the op, `|a|`, `|b|` and the result signs.
  - Signed ops take two's-complement magnitudes; unsigned ops use the operands unchanged.
  - Load counter = WIDTH; go to CALC.
- **CALC** (WIDTH cycles, counter decrements to 0):
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - When counter hits 0, go to FIX.
- **FIX** (1 cycle):
  - Apply sign correction and write `hi`/`lo`.
  - Multiply: {`hi`,`lo`} = full 2·WIDTH product; signed product is negated if operand signs differ.
  - Divide: `lo` = quotient, `hi` = remainder. Quotient is negative iff signs differ; remainder takes the dividend's sign.
  - `done`=1 for exactly this following cycle; return to IDLE.
- **Divide by zero** (`b`=0):
  - Same latency; `lo` = all ones, `hi` = `a` unmodified.
  - Holds for both signed and unsigned divide.
- **Signed overflow** (DIV of MIN_INT by −1): `lo` = MIN_INT (wraps), `hi` = 0. No flag.
- **Cancel**:
  - `cancel`=1 in CALC/FIX: next state IDLE, `hi`/`lo` keep their pre-start values, no `done`.
  - In IDLE, `cancel`=1 blocks `start`, including MTHI/MTLO.
- `start` while `busy`=1 is ignored; no queuing.
- Arithmetic is modulo 2^WIDTH per register. No exceptions are raised.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Let E0 be the edge that accepts the mul/div start:
  - `busy`=1 from after E0 through the edge E(WIDTH+1).
  - Iterations occur at edges E1..E(WIDTH).
  - `hi`/`lo` update at E(WIDTH+1); `done`=1 and `busy`=0 in the cycle after it.
  - Total latency is WIDTH+1 cycles (33 for WIDTH=32).
- A new `start` may be accepted at E(WIDTH+2), i.e. back-to-back in the `done` cycle.
- MTHI/MTLO take effect at the accept edge; values are visible in the next cycle.
- Cancel takes effect at the edge it is sampled: `busy`=0 in the following cycle.
- `hi`/`lo` are registered outputs, stable whenever `busy`=0.

## Test plan
- **Multiply** (WIDTH=32), each checking `done` exactly 33 cycles after accept with single-cycle width:
  - MULT a=0xFFFFFFFF, b=2 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
  - MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **Divide**:
  - DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU a=7, b=2 → `lo`=3, `hi`=1.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero**: DIV a=0x12345678, b=0 → `lo`=0xFFFFFFFF, `hi`=0x12345678.
- **Cancel and ignored start**: after a prior result `hi`=1, `lo`=3:
  - MULT 5×5 with `cancel` pulsed on the 10th CALC cycle → `busy`=0 next cycle, no `done`, `hi`=1, `lo`=3.
  - A `start` during `busy` has no effect.
- **MTHI/MTLO and reset**:
  - MTHI a=0xCAFEF00D in IDLE → `hi`=0xCAFEF00D next cycle, `lo` unchanged, `busy` never rises.
  - `rest` mid-CALC → next cycle `busy`=0, `hi`=`lo`=0, no `done`.
